// File: rtl/i2s_tx_slave_fifo_if.sv
// Frame input channel into the I2S transmitter: one stereo frame per valid/ready handshake.
// Latency: none, wiring only.
// Backpressure: the producer holds in_valid and the frame until in_ready is seen high on a bclk posedge.
interface i2s_tx_slave_fifo_if #(
  parameter int DATA_W = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_l;
  logic [DATA_W-1:0] in_r;

  modport master (output in_valid, output in_l, output in_r, input in_ready);
  modport slave  (input in_valid, input in_l, input in_r, output in_ready);
endinterface

// File: rtl/i2s_tx_slave_fifo.sv
// I2S slave transmitter with stereo frame FIFO, bclk only; optional mute input under `I2S_TX_MUTE_EN`.
// Latency: MSB of a frame appears one negedge after the first left slot start that sees it stored.
// Backpressure: in_ready is low while DEPTH frames are held; underrun loads zeros or the last frame.
module i2s_tx_slave_fifo #(
  parameter int DATA_W          = 16,
  parameter int DEPTH           = 4,
  parameter int UNDERRUN_REPEAT = 0
) (
  input  logic                   bclk,
  input  logic                   rst,
  input  logic                   lrck,
  output logic                   sdata,
  i2s_tx_slave_fifo_if.slave     in_if,
  output logic [$clog2(DEPTH):0] fill,
  output logic                   underrun
`ifdef I2S_TX_MUTE_EN
  ,
  input  logic                   mute
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int FW = PW + 1;
  localparam int CW = $clog2(DATA_W);

  // posedge-domain state
  logic              lrck_d1_q, lrck_d1_d;
  logic              lrck_d2_q, lrck_d2_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [FW-1:0]     fill_q, fill_d;
  logic              in_ready_q, in_ready_d;
  logic              underrun_q, underrun_d;
  logic [DATA_W-1:0] mem_l_q [DEPTH];
  logic [DATA_W-1:0] mem_r_q [DEPTH];

  // negedge-domain state
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              sdata_q, sdata_d;
  logic [DATA_W-1:0] cur_r_q, cur_r_d;
  logic [DATA_W-1:0] last_l_q, last_l_d;
  logic [DATA_W-1:0] last_r_q, last_r_d;

  logic              slot_start, left_start, right_start;
  logic              fifo_empty, push, pop;
  logic [DATA_W-1:0] head_l, head_r;
  logic              load;
  logic [DATA_W-1:0] load_word;

  // Slot detection and FIFO handshake; the pop decided on a left-start negedge commits on the next posedge.
  always_comb begin
    slot_start  = (lrck_d1_q != lrck_d2_q);
    left_start  = slot_start && !lrck_d1_q;
    right_start = slot_start && lrck_d1_q;
    fifo_empty  = (fill_q == '0);
    push        = in_if.in_valid && in_ready_q;
    pop         = left_start && !fifo_empty;
    head_l      = mem_l_q[rd_ptr_q];
    head_r      = mem_r_q[rd_ptr_q];
  end

  // Next state for the lrck synchroniser, FIFO pointers/occupancy and the underrun pulse.
  always_comb begin
    lrck_d1_d  = lrck;
    lrck_d2_d  = lrck_d1_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fill_d     = fill_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   fill_d = fill_q + 1'b1;
      2'b01:   fill_d = fill_q - 1'b1;
      default: fill_d = fill_q;
    endcase
    in_ready_d = (fill_d != FW'(DEPTH));
    underrun_d = left_start && fifo_empty;
  end

  // Posedge registers: synchroniser, pointers, occupancy, handshake and status.
  always_ff @(posedge bclk or negedge rst) begin
    if (!rst) begin
      lrck_d1_q  <= 1'b0;
      lrck_d2_q  <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fill_q     <= '0;
      in_ready_q <= 1'b1;
      underrun_q <= 1'b0;
    end else begin
      lrck_d1_q  <= lrck_d1_d;
      lrck_d2_q  <= lrck_d2_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fill_q     <= fill_d;
      in_ready_q <= in_ready_d;
      underrun_q <= underrun_d;
    end
  end

  // Frame storage; contents are only read while occupancy says they are valid, so no reset.
  always_ff @(posedge bclk) begin
    if (push) begin
      mem_l_q[wr_ptr_q] <= in_if.in_l;
      mem_r_q[wr_ptr_q] <= in_if.in_r;
    end
  end

  // Word selection at slot starts and the MSB-first shifter with zero padding after the LSB.
  always_comb begin
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    sdata_d   = 1'b0;
    cur_r_d   = cur_r_q;
    last_l_d  = last_l_q;
    last_r_d  = last_r_q;
    load      = 1'b0;
    load_word = '0;
    if (left_start) begin
      load = 1'b1;
      if (!fifo_empty) begin
        load_word = head_l;
        cur_r_d   = head_r;
        last_l_d  = head_l;
        last_r_d  = head_r;
      end else if (UNDERRUN_REPEAT != 0) begin
        load_word = last_l_q;
        cur_r_d   = last_r_q;
      end else begin
        load_word = '0;
        cur_r_d   = '0;
      end
    end else if (right_start) begin
      load      = 1'b1;
      load_word = cur_r_q;
    end
`ifdef I2S_TX_MUTE_EN
    // Mute only blanks what is shifted out; the held right sample and repeat frame stay real.
    if (mute) load_word = '0;
`endif
    if (load) begin
      // A slot start always reloads, dropping any untransmitted LSBs of a short slot.
      shift_d = load_word;
      sdata_d = load_word[DATA_W-1];
      cnt_d   = CW'(DATA_W - 1);
    end else if (cnt_q != '0) begin
      shift_d = shift_q << 1;
      sdata_d = shift_q[DATA_W-2];
      cnt_d   = cnt_q - 1'b1;
    end
  end

  // Negedge output stage so the codec samples stable data on the following posedge.
  always_ff @(negedge bclk or negedge rst) begin
    if (!rst) begin
      shift_q  <= '0;
      cnt_q    <= '0;
      sdata_q  <= 1'b0;
      cur_r_q  <= '0;
      last_l_q <= '0;
      last_r_q <= '0;
    end else begin
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      sdata_q  <= sdata_d;
      cur_r_q  <= cur_r_d;
      last_l_q <= last_l_d;
      last_r_q <= last_r_d;
    end
  end

  assign sdata          = sdata_q;
  assign fill           = fill_q;
  assign underrun       = underrun_q;
  assign in_if.in_ready = in_ready_q;

endmodule
